// File: rtl/id_arb_pkg.sv
// Shared encodings and request/result types for the id_arb string arbiter.
// The separator default is the char that returns the checker to its start state.
package id_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

  localparam logic [7:0] SEP_DEFAULT = 8'h2F;

  typedef struct packed {
    logic       valid;
    logic [7:0] chr;
    logic       last;
  } prod_req_t;

  typedef struct packed {
    logic valid;
    logic src;
    logic match;
    logic err;
  } res_t;

endpackage

// File: rtl/id_rr_pick.sv
// Two-way round-robin pick: prio names the preferred source, the other wins
// only when the preferred one has nothing to offer.
module id_rr_pick (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic prio_i,
  output logic gnt_o,
  output logic any_o
);

  assign any_o = valid0_i | valid1_i;
  assign gnt_o = prio_i ? valid1_i : ~valid0_i;

endmodule

// File: rtl/id_arb.sv
// Shares one identifier checker between two string producers: one whole string
// per grant, verdict captured after the last char, checker flushed with SEP between.
module id_arb
  import id_arb_pkg::*;
#(
  parameter logic [7:0] SEP   = SEP_DEFAULT,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_valid,
  input  logic [7:0]       r0_char,
  input  logic             r0_last,
  output logic             r0_ready,
  input  logic             r1_valid,
  input  logic [7:0]       r1_char,
  input  logic             r1_last,
  output logic             r1_ready,
  output logic [7:0]       chk_char,
  input  logic             chk_out,
  output logic             res_valid,
  output logic             res_src,
  output logic             res_match,
  output logic             res_err,
  output logic [CNT_W-1:0] match_cnt0,
  output logic [CNT_W-1:0] match_cnt1
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  prio_q, prio_d;
  logic                  err_q, err_d;
  res_t                  res_q, res_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  prod_req_t req0, req1, req_g;
  logic      pick_gnt, pick_any;

  assign req0  = '{valid: r0_valid, chr: r0_char, last: r0_last};
  assign req1  = '{valid: r1_valid, chr: r1_char, last: r1_last};
  assign req_g = grant_q ? req1 : req0;

  id_rr_pick u_pick (
    .valid0_i (r0_valid),
    .valid1_i (r1_valid),
    .prio_i   (prio_q),
    .gnt_o    (pick_gnt),
    .any_o    (pick_any)
  );

  // Readys depend only on state/grant so a producer never sees a combinational loop.
  assign r0_ready = ~reset & (state_q == ST_STREAM) & ~grant_q;
  assign r1_ready = ~reset & (state_q == ST_STREAM) &  grant_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    prio_d    = prio_q;
    err_d     = err_q;
    res_d     = res_q;
    res_d.valid = 1'b0;
    cnt_d     = cnt_q;
    chk_char  = SEP;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_gnt;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (req_g.valid) begin
          chk_char = req_g.chr;
          if (req_g.last) begin
            err_d   = 1'b0;
            state_d = ST_RESULT;
          end
        end else begin
          err_d   = 1'b1;
          state_d = ST_RESULT;
        end
      end
      ST_RESULT: begin
        // chk_out already covers the final char; SEP goes out this cycle.
        res_d = '{valid: 1'b1, src: grant_q, match: chk_out & ~err_q, err: err_q};
        if (res_d.match && !(&cnt_q[grant_q]))
          cnt_d[grant_q] = cnt_q[grant_q] + CNT_ONE;
        prio_d  = ~grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) chk_char = SEP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign res_valid  = res_q.valid;
  assign res_src    = res_q.src;
  assign res_match  = res_q.match;
  assign res_err    = res_q.err;
  assign match_cnt0 = cnt_q[0];
  assign match_cnt1 = cnt_q[1];

endmodule

// File: tb/tb_id_arb.sv
// Bench for id_arb: a string-level planner derives per-cycle expectations,
// a stand-in identifier checker closes the loop, literal pins fix key timings.
module tb_id_arb;

  localparam logic [7:0] SEP = 8'h2F;
  localparam int MAXC = 64;
  localparam int MAXR = 16;

  logic clk = 1'b0;
  logic reset;
  logic r0_valid, r0_last, r0_ready, r1_valid, r1_last, r1_ready;
  logic [7:0] r0_char, r1_char, chk_char, chk_char2;
  logic chk_out;
  logic res_valid, res_src, res_match, res_err;
  logic [15:0] match_cnt0, match_cnt1;
  logic r0_ready2, r1_ready2, res_valid2, res_src2, res_match2, res_err2;
  logic [1:0] m2_cnt0, m2_cnt1;

  always #5 clk = ~clk;

  id_arb #(.SEP(SEP), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_char(r0_char), .r0_last(r0_last), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_char(r1_char), .r1_last(r1_last), .r1_ready(r1_ready),
    .chk_char(chk_char), .chk_out(chk_out),
    .res_valid(res_valid), .res_src(res_src), .res_match(res_match), .res_err(res_err),
    .match_cnt0(match_cnt0), .match_cnt1(match_cnt1)
  );

  id_arb #(.SEP(SEP), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_char(r0_char), .r0_last(r0_last), .r0_ready(r0_ready2),
    .r1_valid(r1_valid), .r1_char(r1_char), .r1_last(r1_last), .r1_ready(r1_ready2),
    .chk_char(chk_char2), .chk_out(chk_out),
    .res_valid(res_valid2), .res_src(res_src2), .res_match(res_match2), .res_err(res_err2),
    .match_cnt0(m2_cnt0), .match_cnt1(m2_cnt1)
  );

  // Stand-in checker: out=1 iff text since last SEP is letters+ then digits+.
  logic [1:0] ck_q;
  function automatic bit is_let(logic [7:0] c);
    return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z");
  endfunction
  function automatic bit is_dig(logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction
  assign chk_out = (ck_q == 2'd2);
  always @(posedge clk) begin
    if (reset || chk_char == SEP) ck_q <= 2'd0;
    else case (ck_q)
      2'd0: ck_q <= is_let(chk_char) ? 2'd1 : 2'd3;
      2'd1: ck_q <= is_let(chk_char) ? 2'd1 : (is_dig(chk_char) ? 2'd2 : 2'd3);
      2'd2: ck_q <= is_dig(chk_char) ? 2'd2 : 2'd3;
      default: ck_q <= 2'd3;
    endcase
  end

  function automatic bit is_ident(string s);
    int i = 0, nl = 0, nd = 0;
    while (i < s.len() && is_let(s[i])) begin nl++; i++; end
    while (i < s.len() && is_dig(s[i])) begin nd++; i++; end
    return nl > 0 && nd > 0 && i == s.len();
  endfunction

  // Stimulus and expectation tables, indexed by cycle within a phase.
  logic       d_rst [MAXC];
  logic       d_v   [2][MAXC];
  logic [7:0] d_c   [2][MAXC];
  logic       d_l   [2][MAXC];
  logic       e_rdy [2][MAXC];
  logic [7:0] e_chk [MAXC];
  logic       e_rv  [MAXC];
  logic       e_rsrc[MAXC];
  logic       e_rm  [MAXC];
  logic       e_re  [MAXC];
  int         e_inc [2][MAXC];
  int         e_cnt [2][MAXC];

  int    rq_src[MAXR], rq_ab[MAXR], rq_req[MAXR];
  string rq_s[MAXR];
  int    n_rq;

  int obs_cyc[$], obs_src[$], obs_m[$], obs_e[$];
  int nvec = 0, nerr = 0;
  int cyc = 0;
  bit run = 1'b0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic clear();
    for (int c = 0; c < MAXC; c++) begin
      d_rst[c] = (c < 2);
      e_chk[c] = SEP; e_rv[c] = 1'b0; e_rsrc[c] = 1'b0; e_rm[c] = 1'b0; e_re[c] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        d_v[k][c] = 1'b0; d_c[k][c] = 8'h00; d_l[k][c] = 1'b0;
        e_rdy[k][c] = 1'b0; e_inc[k][c] = 0; e_cnt[k][c] = 0;
      end
    end
    n_rq = 0;
    obs_cyc.delete(); obs_src.delete(); obs_m.delete(); obs_e.delete();
  endtask

  task automatic add(int src, string s, int ab, int req);
    rq_src[n_rq] = src; rq_s[n_rq] = s; rq_ab[n_rq] = ab; rq_req[n_rq] = req;
    n_rq++;
  endtask

  // String-level schedule: grant at t, N accepts, result two cycles later
  // (three after an abort); the next grant decision shares the result cycle.
  task automatic plan();
    int t, pr, left, src, i, g, n, r, len, acc;
    int ff[2], h[2], s[2];
    bit done[MAXR];
    t = 2; pr = 0; left = n_rq; ff[0] = 0; ff[1] = 0;
    for (int k = 0; k < MAXR; k++) done[k] = 1'b0;
    while (left > 0) begin
      for (int k = 0; k < 2; k++) begin
        h[k] = -1; s[k] = 1 << 20;
        for (int j = n_rq - 1; j >= 0; j--) if (!done[j] && rq_src[j] == k) h[k] = j;
        if (h[k] >= 0) s[k] = (rq_req[h[k]] > ff[k]) ? rq_req[h[k]] : ff[k];
      end
      if (s[0] > t && s[1] > t) t = (s[0] < s[1]) ? s[0] : s[1];
      if (pr == 1) src = (s[1] <= t) ? 1 : 0;
      else         src = (s[0] <= t) ? 0 : 1;
      i = h[src]; done[i] = 1'b1; left--;
      g = t; len = rq_s[i].len();
      n = (rq_ab[i] < 0) ? len : rq_ab[i];
      for (int c = s[src]; c <= g && c < MAXC; c++) begin
        d_v[src][c] = 1'b1; d_c[src][c] = rq_s[i][0]; d_l[src][c] = (rq_ab[i] < 0 && len == 1);
      end
      for (int k = 0; k < n; k++) begin
        acc = g + 1 + k;
        if (acc < MAXC) begin
          d_v[src][acc] = 1'b1; d_c[src][acc] = rq_s[i][k];
          d_l[src][acc] = (rq_ab[i] < 0 && k == len - 1);
          e_rdy[src][acc] = 1'b1; e_chk[acc] = rq_s[i][k];
        end
      end
      if (rq_ab[i] >= 0) begin
        if (g + 1 + n < MAXC) e_rdy[src][g + 1 + n] = 1'b1;
        r = g + n + 3; ff[src] = g + n + 2;
      end else begin
        r = g + n + 2; ff[src] = g + n + 1;
      end
      if (r < MAXC) begin
        e_rv[r] = 1'b1; e_rsrc[r] = src[0];
        e_rm[r] = (rq_ab[i] < 0) && is_ident(rq_s[i]);
        e_re[r] = (rq_ab[i] >= 0);
        if (e_rm[r]) e_inc[src][r] = 1;
      end
      pr = 1 - src; t = r;
    end
    for (int k = 0; k < 2; k++) begin
      int acc_c = 0;
      for (int c = 0; c < MAXC; c++) begin acc_c += e_inc[k][c]; e_cnt[k][c] = acc_c; end
    end
  endtask

  task automatic run_phase(int len);
    plan();
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      cyc = c; reset = d_rst[c];
      r0_valid = d_v[0][c]; r0_char = d_c[0][c]; r0_last = d_l[0][c];
      r1_valid = d_v[1][c]; r1_char = d_c[1][c]; r1_last = d_l[1][c];
      run = 1'b1;
    end
    @(negedge clk); #1;
    run = 1'b0;
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("chk_char", 32'(chk_char), 32'(e_chk[cyc]));
      chk("chk_char_w2", 32'(chk_char2), 32'(e_chk[cyc]));
      chk("r0_ready", 32'(r0_ready), 32'(e_rdy[0][cyc]));
      chk("r1_ready", 32'(r1_ready), 32'(e_rdy[1][cyc]));
      if (cyc >= 1) begin
        chk("res_valid", 32'(res_valid), 32'(e_rv[cyc]));
        if (e_rv[cyc]) begin
          chk("res_src", 32'(res_src), 32'(e_rsrc[cyc]));
          chk("res_match", 32'(res_match), 32'(e_rm[cyc]));
          chk("res_err", 32'(res_err), 32'(e_re[cyc]));
        end
        chk("match_cnt0", 32'(match_cnt0), 32'(e_cnt[0][cyc]));
        chk("match_cnt1", 32'(match_cnt1), 32'(e_cnt[1][cyc]));
        chk("cnt0_w2", 32'(m2_cnt0), 32'((e_cnt[0][cyc] > 3) ? 3 : e_cnt[0][cyc]));
        chk("cnt1_w2", 32'(m2_cnt1), 32'((e_cnt[1][cyc] > 3) ? 3 : e_cnt[1][cyc]));
        if (res_valid) begin
          obs_cyc.push_back(cyc); obs_src.push_back(32'(res_src));
          obs_m.push_back(32'(res_match)); obs_e.push_back(32'(res_err));
        end
      end
    end
  end

  task automatic pin(int idx, int c, int src, int m, int e);
    if (idx >= obs_cyc.size()) begin
      chk("pin_missing", 32'(obs_cyc.size()), 32'(idx + 1));
    end else begin
      chk("pin_cyc", 32'(obs_cyc[idx]), 32'(c));
      chk("pin_src", 32'(obs_src[idx]), 32'(src));
      chk("pin_match", 32'(obs_m[idx]), 32'(m));
      chk("pin_err", 32'(obs_e[idx]), 32'(e));
    end
  endtask

  initial begin
    reset = 1'b1;
    r0_valid = 1'b0; r0_char = 8'h00; r0_last = 1'b0;
    r1_valid = 1'b0; r1_char = 8'h00; r1_last = 1'b0;

    // Single strings from each source, one match and one non-match.
    clear(); add(0, "abcd1234", -1, 2); add(1, "12ab", -1, 20); run_phase(30);
    chk("p1_nres", 32'(obs_cyc.size()), 32'd2);
    pin(0, 12, 0, 1, 0); pin(1, 26, 1, 0, 0);

    // Simultaneous requests twice: r0 wins both times after r1 took the last turn.
    clear();
    add(0, "x9", -1, 2); add(1, "ab12", -1, 2);
    add(0, "q7", -1, 20); add(1, "zz99", -1, 20);
    run_phase(34);
    chk("p2_nres", 32'(obs_cyc.size()), 32'd4);
    pin(0, 6, 0, 1, 0); pin(1, 12, 1, 1, 0); pin(2, 24, 0, 1, 0); pin(3, 30, 1, 1, 0);

    // After an r0 result, a simultaneous request goes to r1.
    clear(); add(0, "k1", -1, 2); add(0, "m2", -1, 10); add(1, "n3", -1, 10); run_phase(22);
    chk("p3_nres", 32'(obs_cyc.size()), 32'd3);
    pin(0, 6, 0, 1, 0); pin(1, 14, 1, 1, 0); pin(2, 18, 0, 1, 0);

    // Abort after two chars, then a clean string.
    clear(); add(0, "abcd", 2, 2); add(0, "a1", -1, 12); run_phase(20);
    chk("p4_nres", 32'(obs_cyc.size()), 32'd2);
    pin(0, 7, 0, 0, 1); pin(1, 16, 0, 1, 0);

    // r1 matches, then reset lands in the middle of its next string.
    clear(); add(1, "b2", -1, 2); add(1, "abcdef12", -1, 8); run_phase(12);
    chk("p5_nres", 32'(obs_cyc.size()), 32'd1);
    pin(0, 6, 1, 1, 0);
    clear(); add(0, "ab3", -1, 3); run_phase(14);
    chk("p6_nres", 32'(obs_cyc.size()), 32'd1);
    pin(0, 8, 0, 1, 0);

    // Four matches: the 2-bit counter saturates at 3.
    clear();
    for (int k = 0; k < 4; k++) add(0, "a1", -1, 2);
    run_phase(22);
    chk("sat_cnt0_w2", 32'(m2_cnt0), 32'd3);
    chk("cnt0_w16", 32'(match_cnt0), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
